uart_prog_loader: RTL

Receive-side counterpart of the debug unit's word serializer. The debug unit splits 32-bit words into UART bytes MSB-first; this block rebuilds such words from the UART receiver's byte stream and writes them into instruction memory. It sits between the UART RX and the instruction-memory write port, next to the debug unit on the same UART. Step commands are ignored here.

---
 rtl/uart_prog_loader_pkg.sv | 18 +
 rtl/uart_prog_loader_if.sv | 35 +++
 rtl/uart_prog_loader_assembler.sv | 37 +++
 rtl/uart_prog_loader.sv | 136 +++++++++++++
 4 files changed

// File: rtl/uart_prog_loader_pkg.sv
// Shared debug definitions: FSM state encodings and UART command bytes,
// used by both this loader and the debug unit on the same UART.
package uart_prog_loader_pkg;

   typedef enum logic [3:0] {
      ST_IDLE     = 4'd1,
      ST_RX_COUNT = 4'd2,
      ST_RX_WORD  = 4'd3,
      ST_DONE     = 4'd4,
      ST_SEND_ACK = 4'd5,
      ST_WAIT_ACK = 4'd6
   } state_e;

   localparam logic [7:0] CMD_STEP = 8'h73;
   localparam logic [7:0] CMD_LOAD = 8'h6C;
   localparam logic [7:0] ACK_BYTE = 8'h6B;

endpackage

// File: rtl/uart_prog_loader_if.sv
// Loader bus: UART RX/TX side, instruction-memory write port and status.
// master = the loader itself, slave = the surrounding system.
interface uart_prog_loader_if #(
   parameter int NB        = 32,
   parameter int DATA_BITS = 8,
   parameter int ADDR_BITS = 10
);
   // Handshakes: i_uart_rx_ready is a one-cycle strobe qualifying i_uart_rx_data;
   // o_uart_tx_ready is a level request held until the one-cycle i_uart_tx_done;
   // o_imem_wr_en is a one-cycle strobe qualifying o_imem_addr/o_imem_data.
   logic                 i_uart_rx_ready;
   logic [DATA_BITS-1:0] i_uart_rx_data;
   logic                 i_uart_tx_done;
   logic [DATA_BITS-1:0] o_uart_tx_data;
   logic                 o_uart_tx_ready;
   logic                 o_imem_wr_en;
   logic [ADDR_BITS-1:0] o_imem_addr;
   logic [NB-1:0]        o_imem_data;
   logic                 o_loading;
   logic                 o_load_done;
   logic [3:0]           o_state_debug;

   modport master (
      input  i_uart_rx_ready, i_uart_rx_data, i_uart_tx_done,
      output o_uart_tx_data, o_uart_tx_ready, o_imem_wr_en, o_imem_addr,
             o_imem_data, o_loading, o_load_done, o_state_debug
   );

   modport slave (
      output i_uart_rx_ready, i_uart_rx_data, i_uart_tx_done,
      input  o_uart_tx_data, o_uart_tx_ready, o_imem_wr_en, o_imem_addr,
             o_imem_data, o_loading, o_load_done, o_state_debug
   );

endinterface

// File: rtl/uart_prog_loader_assembler.sv
// uart_word_assembler: packs MSB-first UART bytes into NB-bit words.
// word_o / word_valid_o are combinational so the caller can register the strobe.
module uart_word_assembler #(
   parameter int NB        = 32,
   parameter int DATA_BITS = 8
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   input  logic [DATA_BITS-1:0] byte_i,
   input  logic                 valid_i,
   input  logic                 clear_i,
   output logic [NB-1:0]        word_o,
   output logic                 word_valid_o
);

   logic [NB-1:0] word_q;
   logic [NB-1:0] word_d;
   logic [1:0]    cnt_q;

   assign word_d       = {word_q[NB-DATA_BITS-1:0], byte_i};
   assign word_o       = word_d;
   assign word_valid_o = valid_i && !clear_i && (cnt_q == 2'd3);

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         word_q <= '0;
         cnt_q  <= '0;
      end else if (clear_i) begin
         word_q <= '0;
         cnt_q  <= '0;
      end else if (valid_i) begin
         word_q <= word_d;
         cnt_q  <= cnt_q + 2'd1;
      end
   end

endmodule

// File: rtl/uart_prog_loader.sv
// Program loader: 'l', count N, then N MSB-first words written to instruction memory.
// Define LOADER_ACK_EN to send one 'k' ack byte after each load.
module uart_prog_loader
   import uart_prog_loader_pkg::*;
#(
   parameter int NB        = 32,
   parameter int DATA_BITS = 8,
   parameter int ADDR_BITS = 10
) (
   input logic              i_clk,
   input logic              i_reset,
   uart_prog_loader_if.master bus
);

   state_e               state_q;
   logic [7:0]           remaining_q;
   logic [ADDR_BITS-1:0] wr_ptr_q;
   logic                 wr_en_q;
   logic [ADDR_BITS-1:0] imem_addr_q;
   logic [NB-1:0]        imem_data_q;
   logic                 load_done_q;
   logic [NB-1:0]        asm_word;
   logic                 asm_word_valid;
   logic                 asm_clear;
   logic                 asm_valid;

   // Assembler only runs in RX_WORD; any other state discards a partial word.
   assign asm_clear = (state_q != ST_RX_WORD);
   assign asm_valid = bus.i_uart_rx_ready && (state_q == ST_RX_WORD);

   uart_word_assembler #(.NB(NB), .DATA_BITS(DATA_BITS)) u_asm (
      .i_clk        (i_clk),
      .i_reset      (i_reset),
      .byte_i       (bus.i_uart_rx_data),
      .valid_i      (asm_valid),
      .clear_i      (asm_clear),
      .word_o       (asm_word),
      .word_valid_o (asm_word_valid)
   );

`ifdef LOADER_ACK_EN
   logic                 tx_ready_q;
   logic [DATA_BITS-1:0] tx_data_q;
`endif

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q     <= ST_IDLE;
         remaining_q <= '0;
         wr_ptr_q    <= '0;
         wr_en_q     <= 1'b0;
         imem_addr_q <= '0;
         imem_data_q <= '0;
         load_done_q <= 1'b0;
`ifdef LOADER_ACK_EN
         tx_ready_q  <= 1'b0;
         tx_data_q   <= '0;
`endif
      end else begin
         wr_en_q     <= 1'b0;
         load_done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (bus.i_uart_rx_ready && (bus.i_uart_rx_data == DATA_BITS'(CMD_LOAD)))
                  state_q <= ST_RX_COUNT;
            end
            ST_RX_COUNT: begin
               if (bus.i_uart_rx_ready) begin
                  remaining_q <= 8'(bus.i_uart_rx_data);
                  wr_ptr_q    <= '0;
                  if (bus.i_uart_rx_data == '0) begin
                     state_q     <= ST_DONE;
                     load_done_q <= 1'b1;
                  end else begin
                     state_q <= ST_RX_WORD;
                  end
               end
            end
            ST_RX_WORD: begin
               if (asm_word_valid) begin
                  wr_en_q     <= 1'b1;
                  imem_addr_q <= wr_ptr_q;
                  imem_data_q <= asm_word;
                  wr_ptr_q    <= wr_ptr_q + ADDR_BITS'(1);
                  remaining_q <= remaining_q - 8'd1;
                  // load_done lands in DONE together with the final strobe
                  if (remaining_q == 8'd1) begin
                     state_q     <= ST_DONE;
                     load_done_q <= 1'b1;
                  end
               end
            end
`ifdef LOADER_ACK_EN
            ST_DONE: state_q <= ST_SEND_ACK;
            ST_SEND_ACK: begin
               tx_data_q  <= DATA_BITS'(ACK_BYTE);
               tx_ready_q <= 1'b1;
               state_q    <= ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
               if (bus.i_uart_tx_done) begin
                  tx_ready_q <= 1'b0;
                  tx_data_q  <= '0;
                  state_q    <= ST_IDLE;
               end
            end
`else
            ST_DONE: state_q <= ST_IDLE;
`endif
            default: begin
               state_q     <= ST_IDLE;
               remaining_q <= '0;
               wr_ptr_q    <= '0;
            end
         endcase
      end
   end

   assign bus.o_imem_wr_en  = wr_en_q;
   assign bus.o_imem_addr   = imem_addr_q;
   assign bus.o_imem_data   = imem_data_q;
   assign bus.o_load_done   = load_done_q;
   assign bus.o_loading     = (state_q != ST_IDLE);
   assign bus.o_state_debug = state_q;

`ifdef LOADER_ACK_EN
   assign bus.o_uart_tx_ready = tx_ready_q;
   assign bus.o_uart_tx_data  = tx_data_q;
`else
   logic unused_tx_done;
   assign unused_tx_done      = bus.i_uart_tx_done;
   assign bus.o_uart_tx_ready = 1'b0;
   assign bus.o_uart_tx_data  = '0;
`endif

endmodule
